rbm_gibbs_controller: RTL and testbench
=======================================

# rbm_gibbs_controller

Sequencing controller for one RBM visible/hidden layer pair. It runs contrastive-divergence Gibbs chains: v0→h0, then k×(h→v→h). It drives each layer's reset, data_valid and random-generator reset, waits on the layer's finish flag, and latches the sampled vectors between phases. It sits above two layer instances, hidden (visible_dim→hidden_dim) and reconstruction (hidden_dim→visible_dim), and below the training/inference top level.

## Interface
- visible_dim, 15, visible vector width
- hidden_dim, 5, hidden vector width
- step_bits, 4, width of k and step counter
- timeout_cycles, 4096, watchdog limit per run phase; used only with RBM_CTRL_TIMEOUT_EN
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a chain; sampled only in IDLE
- k  in  step_bits  Gibbs steps; sampled with start; 0 = single inference pass
- VisibleIn  in  visible_dim  initial visible vector v0, sampled with start
- h_reset  out  1  hidden-layer reset
- h_valid  out  1  hidden-layer data_valid
- h_finish  in  1  hidden-layer finish
- h_out  in  hidden_dim  hidden-layer OutputData
- h_in  out  visible_dim  hidden-layer InputData = visible register
- v_reset  out  1  reconstruction-layer reset
- v_valid  out  1  reconstruction-layer data_valid
- v_finish  in  1  reconstruction-layer finish
- v_out  in  visible_dim  reconstruction-layer OutputData
- v_in  out  hidden_dim  reconstruction-layer InputData = hidden register
- rand_reset  out  1  reset to both layers' random generators
- VisibleOut  out  visible_dim  visible register (vk at done)
- HiddenOut  out  hidden_dim  hidden register (hk at done)
- Hidden0Out  out  hidden_dim  h0, latched at the first hidden capture
- step_count  out  step_bits  completed Gibbs steps
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at chain end
- error  out  1  watchdog expired; sticky until the next accepted start

## Operation
- States: IDLE, H_RUN, H_CAP, V_RUN, V_CAP, DONE. Moore decode from the state register. No combinational path from inputs to control outputs.
- h_reset is 1 in all states except H_RUN. v_reset is 1 in all states except V_RUN. h_valid = (state==H_RUN). v_valid = (state==V_RUN). rand_reset = (state==IDLE).
- IDLE, start=1 on an edge: latch VisibleIn→visible register and k→k register, clear step_count and error, go to H_RUN.
- H_RUN: stay until h_finish=1 is sampled, then go to H_CAP.
- H_CAP: h_out→hidden register. If this is the first capture of the chain, also h_out→Hidden0Out. If step_count==k, go to DONE; otherwise go to V_RUN.
- V_RUN: stay until v_finish=1, then go to V_CAP.
- V_CAP: v_out→visible register, step_count+1, go to H_RUN.
- DONE: done=1 for one cycle, then go to IDLE. The result registers hold until the next start.
- Every RUN state is entered from a state where that layer's reset is high, so the layer's cursor is always cleared before valid rises.
- start while busy is ignored. k may change while busy; only the latched copy is used.
- No wrap-around condition exists: step_count never exceeds k ≤ 2^step_bits−1.

## Timing
- Reset (synchronous): state=IDLE; all result registers 0; step_count=0; done=0; error=0; busy=0; h_valid=v_valid=0; h_reset=v_reset=rand_reset=1.
- Reset asserted mid-chain returns to IDLE on the same edge, with no done pulse. The layers are held reset from the next cycle.
- Let Th and Tv be the number of H_RUN and V_RUN cycles (through the cycle h_finish/v_finish is sampled). busy rises 1 cycle after the start edge. done is high in cycle (k+1)·(Th+1) + k·(Tv+1) + 1 after the start edge.
- h_finish and v_finish are ignored outside their own RUN state.

## Configuration
- RBM_CTRL_TIMEOUT_EN defined: a per-phase counter clears on entry to H_RUN or V_RUN and increments each RUN cycle. When it reaches timeout_cycles with finish still low, the FSM sets error=1 and goes to DONE; the done pulse is still issued and the registers keep their partial values.
- RBM_CTRL_TIMEOUT_EN undefined: no counter. RUN states wait indefinitely, and error is constant 0.

## Test plan
- Reset, then idle 5 cycles → h_reset=v_reset=rand_reset=1, busy=0, done=0, all outputs 0.
- Behavioral layers with finish after Th=8 and Tv=20; k=0, VisibleIn=15'h5A5A → one H pass only; v_valid never high; done 10 cycles after the start edge; HiddenOut=Hidden0Out=h_out.
- Same layers, k=2 → phase order H,V,H,V,H; step_count=2 at done; done at cycle 3·9+2·21+1=70; Hidden0Out holds the first capture.
- Pulse start in H_RUN with a different VisibleIn → ignored; chain result unchanged.
- Assert reset mid-V_RUN of k=3 → IDLE on the next edge; no done pulse; a new start with k=1 completes normally.
- With RBM_CTRL_TIMEOUT_EN and timeout_cycles=16, hold h_finish=0 → error=1 and done pulse 16 cycles after H_RUN entry; the next start clears error.

Source files
------------

// File: rtl/rbm_gibbs_controller.sv
// Gibbs-chain sequencer for one RBM visible/hidden layer pair: v0->h0, then k x (h->v->h).
// Optional per-phase watchdog is compiled in with RBM_CTRL_TIMEOUT_EN.
module rbm_gibbs_controller #(
    parameter int visible_dim    = 15,
    parameter int hidden_dim     = 5,
    parameter int step_bits      = 4,
    parameter int timeout_cycles = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [step_bits-1:0]   k,
    input  logic [visible_dim-1:0] VisibleIn,
    output logic                   h_reset,
    output logic                   h_valid,
    input  logic                   h_finish,
    input  logic [hidden_dim-1:0]  h_out,
    output logic [visible_dim-1:0] h_in,
    output logic                   v_reset,
    output logic                   v_valid,
    input  logic                   v_finish,
    input  logic [visible_dim-1:0] v_out,
    output logic [hidden_dim-1:0]  v_in,
    output logic                   rand_reset,
    output logic [visible_dim-1:0] VisibleOut,
    output logic [hidden_dim-1:0]  HiddenOut,
    output logic [hidden_dim-1:0]  Hidden0Out,
    output logic [step_bits-1:0]   step_count,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_H_RUN = 3'd1,
        S_H_CAP = 3'd2,
        S_V_RUN = 3'd3,
        S_V_CAP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 r_state;
    logic [visible_dim-1:0] r_visible;
    logic [hidden_dim-1:0]  r_hidden;
    logic [hidden_dim-1:0]  r_hidden0;
    logic [step_bits-1:0]   r_k;
    logic [step_bits-1:0]   r_step;

`ifdef RBM_CTRL_TIMEOUT_EN
    localparam int WDOG_W = $clog2(timeout_cycles + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(timeout_cycles - 1);
    logic [WDOG_W-1:0] r_wdog;
    logic              r_error;
`endif

    // Chain sequencer: state, latched operands and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_visible <= {visible_dim{1'b0}};
            r_hidden  <= {hidden_dim{1'b0}};
            r_hidden0 <= {hidden_dim{1'b0}};
            r_k       <= {step_bits{1'b0}};
            r_step    <= {step_bits{1'b0}};
`ifdef RBM_CTRL_TIMEOUT_EN
            r_wdog    <= {WDOG_W{1'b0}};
            r_error   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_visible <= VisibleIn;
                        r_k       <= k;
                        r_step    <= {step_bits{1'b0}};
                        r_state   <= S_H_RUN;
`ifdef RBM_CTRL_TIMEOUT_EN
                        r_wdog    <= {WDOG_W{1'b0}};
                        r_error   <= 1'b0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_H_RUN: begin
                    if (h_finish) begin
                        r_state <= S_H_CAP;
`ifdef RBM_CTRL_TIMEOUT_EN
                    end else if (r_wdog == WDOG_LAST) begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wdog  <= r_wdog + WDOG_W'(1);
                        r_state <= S_H_RUN;
`else
                    end else begin
                        r_state <= S_H_RUN;
`endif
                    end
                end
                S_H_CAP: begin
                    r_hidden <= h_out;
                    // step_count is still zero only on the chain's first hidden capture
                    if (r_step == {step_bits{1'b0}}) begin
                        r_hidden0 <= h_out;
                    end else begin
                        r_hidden0 <= r_hidden0;
                    end
                    if (r_step == r_k) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_V_RUN;
`ifdef RBM_CTRL_TIMEOUT_EN
                        r_wdog  <= {WDOG_W{1'b0}};
`endif
                    end
                end
                S_V_RUN: begin
                    if (v_finish) begin
                        r_state <= S_V_CAP;
`ifdef RBM_CTRL_TIMEOUT_EN
                    end else if (r_wdog == WDOG_LAST) begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wdog  <= r_wdog + WDOG_W'(1);
                        r_state <= S_V_RUN;
`else
                    end else begin
                        r_state <= S_V_RUN;
`endif
                    end
                end
                S_V_CAP: begin
                    r_visible <= v_out;
                    r_step    <= r_step + step_bits'(1);
                    r_state   <= S_H_RUN;
`ifdef RBM_CTRL_TIMEOUT_EN
                    r_wdog    <= {WDOG_W{1'b0}};
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode: every RUN state is entered from a state holding that layer in reset
    assign h_reset    = (r_state != S_H_RUN);
    assign v_reset    = (r_state != S_V_RUN);
    assign h_valid    = (r_state == S_H_RUN);
    assign v_valid    = (r_state == S_V_RUN);
    assign rand_reset = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

    assign h_in       = r_visible;
    assign v_in       = r_hidden;
    assign VisibleOut = r_visible;
    assign HiddenOut  = r_hidden;
    assign Hidden0Out = r_hidden0;
    assign step_count = r_step;

`ifdef RBM_CTRL_TIMEOUT_EN
    assign error = r_error;
`else
    // Watchdog compiled out: a signed limit is never negative, so error stays 0
    assign error = (timeout_cycles < 0);
`endif

endmodule

// File: tb/tb_rbm_gibbs_controller.sv
// Directed bench for rbm_gibbs_controller with behavioural layers (Th=8, Tv=20).
// Define RBM_CTRL_TIMEOUT_EN to also exercise the watchdog with timeout_cycles=16.
module tb_rbm_gibbs_controller;

    localparam int TH = 8;
    localparam int TV = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  k = 4'd0;
    logic [14:0] VisibleIn = 15'd0;
    logic        h_reset, h_valid, h_finish, v_reset, v_valid, v_finish, rand_reset;
    logic [4:0]  h_out, v_in, HiddenOut, Hidden0Out;
    logic [14:0] h_in, v_out, VisibleOut;
    logic [3:0]  step_count;
    logic        busy, done, error;

    logic        hold_h = 1'b0;
    logic [7:0]  h_cnt, v_cnt;
    int          tests = 0;
    int          fails = 0;
    int          cyc, nh, nv, nboth;
    logic        busy1;

    always #5 clock = ~clock;

    rbm_gibbs_controller #(
        .visible_dim(15), .hidden_dim(5), .step_bits(4), .timeout_cycles(16)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .k(k), .VisibleIn(VisibleIn),
        .h_reset(h_reset), .h_valid(h_valid), .h_finish(h_finish), .h_out(h_out), .h_in(h_in),
        .v_reset(v_reset), .v_valid(v_valid), .v_finish(v_finish), .v_out(v_out), .v_in(v_in),
        .rand_reset(rand_reset), .VisibleOut(VisibleOut), .HiddenOut(HiddenOut),
        .Hidden0Out(Hidden0Out), .step_count(step_count), .busy(busy), .done(done), .error(error)
    );

    // Behavioural layers: finish in the Nth valid cycle after reset drops
    always_ff @(posedge clock) begin
        if (h_reset) h_cnt <= 8'd0;
        else if (h_valid) h_cnt <= h_cnt + 8'd1;
        if (v_reset) v_cnt <= 8'd0;
        else if (v_valid) v_cnt <= v_cnt + 8'd1;
    end
    assign h_finish = h_valid && (h_cnt == 8'(TH - 1)) && !hold_h;
    assign v_finish = v_valid && (v_cnt == 8'(TV - 1));
    assign h_out    = h_in[14:10] ^ h_in[9:5] ^ h_in[4:0];
    assign v_out    = {v_in, v_in, v_in[3:0], v_in[4]};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a chain and run to the done pulse (bounded); optionally poke start mid H_RUN
    task automatic run_chain(input logic [3:0] kk, input logic [14:0] vin, input bit poke);
        k = kk;
        VisibleIn = vin;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1; nh = 0; nv = 0; nboth = 0;
        busy1 = busy;
        while (!done && cyc < 300) begin
            if (h_valid) nh++;
            if (v_valid) nv++;
            if (h_valid && v_valid) nboth++;
            if (poke && cyc == 3) begin
                start = 1'b1;
                VisibleIn = 15'h7FFF;
                k = 4'd5;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        int seen_done;
        // Reset and idle
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rst_h_reset", h_reset, 1);
        check("rst_v_reset", v_reset, 1);
        check("rst_rand_reset", rand_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valids", {h_valid, v_valid}, 0);
        check("rst_visible", VisibleOut, 0);
        check("rst_hidden", {HiddenOut, Hidden0Out}, 0);
        check("rst_step", step_count, 0);
        check("rst_error", error, 0);

        // k=0: single hidden pass, h0 = 16^12^1A = 1E
        run_chain(4'd0, 15'h5A5A, 1'b0);
        check("k0_busy_cycle1", busy1, 1);
        check("k0_done_cycle", cyc, 10);
        check("k0_done", done, 1);
        check("k0_h_cycles", nh, TH);
        check("k0_v_cycles", nv, 0);
        check("k0_visible", VisibleOut, 15'h5A5A);
        check("k0_hidden", HiddenOut, 5'h1E);
        check("k0_hidden0", Hidden0Out, 5'h1E);
        check("k0_step", step_count, 0);
        tick();
        check("k0_done_pulse", done, 0);
        check("k0_idle", {busy, rand_reset}, 2'b01);

        // k=2: h0=1E, v1=7BDD, h1=1D, v2=77BB, h2=1B
        run_chain(4'd2, 15'h5A5A, 1'b0);
        check("k2_done_cycle", cyc, 70);
        check("k2_h_cycles", nh, 3 * TH);
        check("k2_v_cycles", nv, 2 * TV);
        check("k2_overlap", nboth, 0);
        check("k2_visible", VisibleOut, 15'h77BB);
        check("k2_hidden", HiddenOut, 5'h1B);
        check("k2_hidden0", Hidden0Out, 5'h1E);
        check("k2_step", step_count, 2);
        check("k2_error", error, 0);
        tick();

        // start (and new k/VisibleIn) while busy must be ignored
        run_chain(4'd2, 15'h5A5A, 1'b1);
        check("busy_start_done_cycle", cyc, 70);
        check("busy_start_visible", VisibleOut, 15'h77BB);
        check("busy_start_hidden", HiddenOut, 5'h1B);
        check("busy_start_hidden0", Hidden0Out, 5'h1E);
        check("busy_start_step", step_count, 2);
        tick();

        // reset in the middle of V_RUN of a k=3 chain
        k = 4'd3;
        VisibleIn = 15'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && !v_valid; i++) tick();
        check("mid_reach_v_run", v_valid, 1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_busy", busy, 0);
        check("mid_resets", {h_reset, v_reset, rand_reset}, 3'b111);
        check("mid_valids", {h_valid, v_valid}, 0);
        check("mid_step", step_count, 0);
        check("mid_visible", VisibleOut, 0);
        seen_done = 0;
        for (int i = 0; i < 100; i++) begin
            if (done || busy) seen_done++;
            tick();
        end
        check("mid_no_done", seen_done, 0);

        // k=1 after the aborted chain: h0=01, v1=0422, h1=02
        run_chain(4'd1, 15'h0001, 1'b0);
        check("k1_done_cycle", cyc, 40);
        check("k1_visible", VisibleOut, 15'h0422);
        check("k1_hidden", HiddenOut, 5'h02);
        check("k1_hidden0", Hidden0Out, 5'h01);
        check("k1_step", step_count, 1);
        tick();

`ifdef RBM_CTRL_TIMEOUT_EN
        // Watchdog: hidden layer never finishes
        hold_h = 1'b1;
        run_chain(4'd1, 15'h5A5A, 1'b0);
        check("tmo_done_cycle", cyc, 17);
        check("tmo_error", error, 1);
        check("tmo_step", step_count, 0);
        check("tmo_visible", VisibleOut, 15'h5A5A);
        check("tmo_hidden_kept", HiddenOut, 5'h02);
        tick();
        check("tmo_error_sticky", error, 1);
        hold_h = 1'b0;
        run_chain(4'd0, 15'h5A5A, 1'b0);
        check("tmo_recover_cycle", cyc, 10);
        check("tmo_error_cleared", error, 0);
        check("tmo_recover_hidden", HiddenOut, 5'h1E);
        tick();
`else
        check("no_wdog_error", error, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
